// File: rtl/apb_modport_slave.sv
// APB4 completer backed by a word-organised register file with byte strobes, WAIT_CYCLES wait states and slave errors.
// Optional APB_PPROT_CHECK_EN: non-secure (pprot[1]=1) accesses to the top quarter of memory are rejected.
module apb_modport_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(WAIT_CYCLES);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [CNT_W-1:0]      wait_q;
  logic [CNT_W-1:0]      wait_d;
  logic [IDX_W-1:0]      idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  access;
  logic                  addr_ok;
  logic                  legal;

  assign access  = psel & penable;
  assign idx     = paddr[ADDR_WIDTH-1:2];
  assign mem_idx = idx[MEM_AW-1:0];
  assign addr_ok = (paddr[1:0] == 2'b00) && (idx < DEPTH_IDX);

`ifdef APB_PPROT_CHECK_EN
  localparam logic [IDX_W-1:0] SECURE_BASE = IDX_W'(3 * MEM_DEPTH / 4);
  logic unused_prot;
  assign unused_prot = ^{pprot[2], pprot[0]};
  assign legal       = addr_ok && !((idx >= SECURE_BASE) && pprot[1]);
`else
  logic unused_prot;
  assign unused_prot = ^pprot;
  assign legal       = addr_ok;
`endif

  // Outputs are forced low while reset is held, even if the master keeps an access phase up.
  assign pready  = prst & access & (wait_q == WAIT_MAX);
  assign pslverr = pready & ~legal;
  assign prdata  = (pready & ~pwrite & legal) ? mem_q[mem_idx] : '0;

  always_comb begin
    wait_d = wait_q;
    if (!access || pready) begin
      wait_d = '0;
    end else if (wait_q < WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // Writes commit only at the completing edge; errored transfers leave memory untouched.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (pready && pwrite && legal) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (pstrb[b]) begin
          mem_q[mem_idx][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_modport_slave.sv
// Directed bench: a zero-wait instance (u0) and a two-wait-state instance (u2) share the APB bus, each with its own psel.
module tb_apb_modport_slave;

  logic        pclk = 1'b0;
  logic        prst;
  logic [31:0] paddr;
  logic        psel0, psel2, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata2;
  logic        pready0, pready2, pslverr0, pslverr2;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .pclk(pclk), .prst(prst), .paddr(paddr), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(2)) u2 (
    .pclk(pclk), .prst(prst), .paddr(paddr), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
  );

  // Called just after a rising edge; returns just after the completing edge, so calls chain back-to-back.
  task automatic apb_xfer(input bit use2, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output int waits);
    bit got;
    got = 0; waits = 0; rdata = '0; err = 1'b0;
    psel0 = !use2; psel2 = use2; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
    @(posedge pclk); #1 penable = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge pclk);
      if (use2 ? pready2 : pready0) begin
        got   = 1;
        rdata = use2 ? prdata2 : prdata0;
        err   = use2 ? pslverr2 : pslverr0;
      end else begin
        waits++;
      end
      @(posedge pclk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h got no pready, required pready within 20 cycles", addr);
    end
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int w;
    prst = 1'b0; psel0 = 1'b1; psel2 = 1'b0; penable = 1'b1;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    #12;
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL reset_pready got=%b exp=0", pready0); end
    checks++; if (pslverr0 !== 1'b0) begin errors++; $display("FAIL reset_pslverr got=%b exp=0", pslverr0); end
    checks++; if (prdata0 !== 32'h0) begin errors++; $display("FAIL reset_prdata got=%h exp=0", prdata0); end
    @(negedge pclk); prst = 1'b1; psel0 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    apb_xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL first_read_waits got=%0d exp=0", w); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL first_read_data got=%h exp=00000000", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL first_read_err got=%b exp=0", err); end
  endtask

  task automatic test_write_strobe();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL write_outputs got prdata=%h err=%b exp 0/0", rd, err); end
    apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL full_write_read got=%h exp=DEADBEEF", rd); end
    apb_xfer(0, 1, 32'h10, 32'h11223344, 4'b0101, 3'b000, rd, err, w);
    apb_xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b000, rd, err, w);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL strobe_write_read got=%h exp=DE22BE44", rd); end
    apb_xfer(0, 1, 32'h10, 32'h55555555, 4'b0000, 3'b000, rd, err, w);
    checks++; if (err !== 1'b0 || w !== 0) begin errors++; $display("FAIL zero_strobe_complete got err=%b waits=%0d exp 0/0", err, w); end
    apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL zero_strobe_read got=%h exp=DE22BE44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 0, 32'h400, 32'h0, 4'hF, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oob_read got err=%b prdata=%h exp 1/00000000", err, rd); end
    apb_xfer(0, 1, 32'h13, 32'hFFFFFFFF, 4'hF, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1 || w !== 0) begin errors++; $display("FAIL misaligned_write got err=%b waits=%0d exp 1/0", err, w); end
    apb_xfer(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_write got err=%b exp 1", err); end
    apb_xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL after_err_read0 got=%h err=%b exp 00000000/0", rd, err); end
    apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL after_err_read10 got=%h exp=DE22BE44", rd); end
    apb_xfer(0, 1, 32'h3FC, 32'h0BADF00D, 4'hF, 3'b000, rd, err, w);
    apb_xfer(0, 0, 32'h3FC, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h0BADF00D || err !== 1'b0) begin errors++; $display("FAIL last_word got=%h err=%b exp 0BADF00D/0", rd, err); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int w;
    apb_xfer(1, 1, 32'h20, 32'hA5A5A5A5, 4'hF, 3'b000, rd, err, w);
    checks++; if (w !== 2) begin errors++; $display("FAIL wait_write got=%0d exp=2", w); end
    apb_xfer(1, 0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (w !== 2) begin errors++; $display("FAIL wait_read got=%0d exp=2", w); end
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wait_data got=%h exp=A5A5A5A5", rd); end
    apb_xfer(1, 0, 32'h401, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (err !== 1'b1 || w !== 2 || rd !== 32'h0) begin errors++; $display("FAIL wait_err got err=%b waits=%0d prdata=%h exp 1/2/00000000", err, w, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 1, 32'h40, 32'h12345678, 4'hF, 3'b000, rd, err, w);
    apb_xfer(0, 0, 32'h40, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h12345678 || w !== 0) begin errors++; $display("FAIL b2b_raw got=%h waits=%0d exp 12345678/0", rd, w); end
    apb_xfer(1, 1, 32'h44, 32'h0F0F0F0F, 4'hF, 3'b000, rd, err, w);
    apb_xfer(1, 0, 32'h44, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h0F0F0F0F || w !== 2) begin errors++; $display("FAIL b2b_wait got=%h waits=%0d exp 0F0F0F0F/2", rd, w); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hCAFEBABE; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); prst = 1'b0;
    #1;
    checks++; if (pready2 !== 1'b0 || pslverr2 !== 1'b0 || prdata2 !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outputs got pready=%b pslverr=%b prdata=%h exp 0/0/0", pready2, pslverr2, prdata2);
    end
    @(posedge pclk); @(posedge pclk); @(negedge pclk);
    checks++; if (pready2 !== 1'b0 || prdata2 !== 32'h0) begin
      errors++; $display("FAIL mid_reset_hold got pready=%b prdata=%h exp 0/0", pready2, prdata2);
    end
    psel2 = 1'b0; penable = 1'b0; prst = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(1, 0, 32'h30, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h0 || w !== 2) begin errors++; $display("FAIL mid_reset_read got=%h waits=%0d exp 00000000/2", rd, w); end
    apb_xfer(1, 0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_clear got=%h exp 00000000", rd); end
  endtask

`ifdef APB_PPROT_CHECK_EN
  task automatic test_pprot();
    logic [31:0] rd; logic err; int w;
    apb_xfer(0, 1, 32'h300, 32'hCAFEF00D, 4'hF, 3'b010, rd, err, w);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL pprot_ns_write got err=%b exp 1", err); end
    apb_xfer(0, 0, 32'h300, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL pprot_readback got=%h err=%b exp 00000000/0", rd, err); end
    apb_xfer(0, 1, 32'h300, 32'hCAFEF00D, 4'hF, 3'b000, rd, err, w);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pprot_sec_write got err=%b exp 0", err); end
    apb_xfer(0, 0, 32'h300, 32'h0, 4'h0, 3'b010, rd, err, w);
    checks++; if (rd !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL pprot_ns_read got=%h err=%b exp 00000000/1", rd, err); end
    apb_xfer(0, 0, 32'h300, 32'h0, 4'h0, 3'b000, rd, err, w);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL pprot_sec_read got=%h exp CAFEF00D", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_strobe();
    test_errors();
    test_wait_states();
    test_back_to_back();
`ifdef APB_PPROT_CHECK_EN
    test_pprot();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_modport_slave.md
Name: apb_modport_slave

Overview:
- APB4 completer (slave) with a word-organised register-file memory.
- Sits behind the APB master driver/monitor interface and is the target of the master-driver and monitor modports.
- Supports byte-strobed writes, programmable wait states, and an error response on illegal addresses.

Parameters:
- ADDR_WIDTH, 32: width of paddr.
- DATA_WIDTH, 32: width of pwdata/prdata. Only 32 is supported; pstrb width is DATA_WIDTH/8.
- MEM_DEPTH, 256: number of 32-bit words in memory.
- WAIT_CYCLES, 0: wait states inserted in every access phase before pready is asserted.

Ports:
- pclk  input  1  APB clock; all state changes on the rising edge.
- prst  input  1  asynchronous, active-low reset.
- paddr  input  ADDR_WIDTH  byte address.
- psel  input  1  slave select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes; bit i enables byte i.
- pprot  input  3  protection type; used only with the optional feature.
- prdata  output  DATA_WIDTH  read data.
- pready  output  1  transfer-complete indicator.
- pslverr  output  1  error response.

Behaviour:
- Reset (prst low, asynchronous):
  - all memory words set to 0 and the wait counter set to 0;
  - pready, pslverr and prdata are 0 while reset is held.
- Phases:
  - Idle: psel=0.
  - Setup: psel=1, penable=0.
  - Access: psel=1, penable=1.
  - penable with psel=0 is treated as idle.
- Wait counter:
  - cleared in idle and setup;
  - increments by 1 each access-phase cycle while below WAIT_CYCLES, then saturates.
- pready (combinational):
  - 1 when in access phase and counter == WAIT_CYCLES;
  - 0 otherwise.
  - With WAIT_CYCLES=0, a transfer completes in its first access cycle (2 cycles per transfer).
- Completion: the rising edge at which psel & penable & pready = 1. The counter clears after completion.
- Address decode:
  - index = paddr[ADDR_WIDTH-1:2];
  - legal when paddr[1:0]==0 and index < MEM_DEPTH.
- pslverr (combinational):
  - 1 only when pready=1 and the address is illegal;
  - 0 in all other cycles.
- Write:
  - At completion with pwrite=1 and a legal address, each byte i of mem[index] is updated from pwdata[8i+7:8i] where pstrb[i]=1.
  - Bytes with pstrb[i]=0 keep their value.
  - pstrb=0 writes nothing but still completes normally.
  - Errored writes never modify memory.
- Read:
  - prdata = mem[index] while pready=1, pwrite=0 and the address is legal;
  - prdata = 0 otherwise, including errored reads and write transfers.
  - pstrb is ignored on reads.
- Address, data and control must be held stable by the master through wait states. The slave samples them only at completion.
- Back-to-back: a new setup phase may follow completion immediately; no idle cycle is required.
- Reset mid-transfer: the transfer is abandoned, no write occurs, and the counter clears.
- A read that follows a write to the same address returns the newly written data.

Optional Feature:
- Macro: APB_PPROT_CHECK_EN.
- When defined:
  - The top quarter of memory (index >= 3*MEM_DEPTH/4) is a secure region.
  - Any access to it with pprot[1]=1 (non-secure) is illegal: pslverr=1 at completion, prdata=0, no write.
- When undefined: pprot is unused and only address legality determines pslverr.

Test Plan:
- Reset then read address 0x0 -> pready=1 in first access cycle, prdata=0x00000000, pslverr=0.
- Write 0xDEADBEEF to 0x10 with pstrb=4'hF, then read 0x10 -> prdata=0xDEADBEEF. Then write 0x11223344 with pstrb=4'b0101, read 0x10 -> 0xDE22BE44.
- Read 0x400 (index 256), then write 0x13 (misaligned) -> pslverr=1 with pready. Memory unchanged; subsequent reads of 0x0 and 0x10 return prior values.
- WAIT_CYCLES=2: write then read 0x20 -> pready low for the first 2 access cycles, high on the 3rd. Data 0xA5A5A5A5 round-trips.
- Assert prst low during the access phase of a write to 0x30 (WAIT_CYCLES=2), release, read 0x30 -> 0x00000000, and outputs were 0 during reset.
- APB_PPROT_CHECK_EN defined, MEM_DEPTH=256: write 0x300 with pprot=3'b010 -> pslverr=1, readback with pprot=0 returns 0. Same write with pprot=0 succeeds.
